// File: rtl/des_pkg.sv
// DES tables, key-schedule shift amounts and small permutation helpers shared by
// the round engine and its f-function.
package des_pkg;

    localparam int ROUNDS = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Table entries use standard DES numbering: entry n is bit n counted from the MSB.
    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    // Left-rotate amount applied before encrypt round i+1.
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] p;
        p = '0;
        for (int i = 0; i < 56; i++) p[6'(55 - i)] = k[6'(64 - PC1_TBL[6'(i)])];
        return p;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] p;
        p = '0;
        for (int i = 0; i < 48; i++) p[6'(47 - i)] = cd[6'(56 - PC2_TBL[6'(i)])];
        return p;
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expansion, subkey mix, S-box substitution, P permutation.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;

    always_comb begin
        x = '0;
        s = '0;
        b = '0;
        f = '0;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_TBL[6'(i)])];
        x = x ^ k;
        // Outer bits pick the S-box row, inner four bits the column.
        for (int i = 0; i < 8; i++) begin
            b = 6'(x >> (42 - 6 * i));
            s[5'(28 - 4 * i) +: 4] = SBOX[3'(i)][{b[5], b[0], b[4:1]}];
        end
        for (int i = 0; i < 32; i++) f[5'(31 - i)] = s[5'(32 - P_TBL[5'(i)])];
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES round engine: UNROLL Feistel rounds per clock with an on-the-fly
// key schedule, taking post-IP halves and returning swapped halves before FP.
module des_round_engine
    import des_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [31:0] in_l,
    input  logic [31:0] in_r,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_l,
    output logic [31:0] out_r
);

    if (NUM_ROUNDS != ROUNDS) begin : g_bad_rounds
        $error("des_round_engine: NUM_ROUNDS must be 16");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("des_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
    end

    state_t      state, state_next;
    logic [4:0]  rnd;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic        dec_q;
    logic        last;

    logic [31:0] l_ch [UNROLL+1];
    logic [31:0] r_ch [UNROLL+1];
    logic [27:0] c_ch [UNROLL+1];
    logic [27:0] d_ch [UNROLL+1];

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    // Each stage rotates C/D into the subkey for round rnd+j+1, then runs one Feistel round.
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [3:0]  idx;
        logic [1:0]  amt;
        logic [47:0] key;
        logic [31:0] fout;

        assign idx = 4'(rnd + 5'(j));

        // Decrypt starts from the unrotated key, which equals the final encrypt key state.
        always_comb begin
            amt = SHIFTS[idx];
            if (dec_q && idx == 4'd0) amt = 2'd0;
        end

        assign c_ch[j+1] = dec_q ? rotr28(c_ch[j], amt) : rotl28(c_ch[j], amt);
        assign d_ch[j+1] = dec_q ? rotr28(d_ch[j], amt) : rotl28(d_ch[j], amt);
        assign key       = pc2({c_ch[j+1], d_ch[j+1]});

        des_f u_f (
            .r (r_ch[j]),
            .k (key),
            .f (fout)
        );

        assign l_ch[j+1] = r_ch[j];
        assign r_ch[j+1] = l_ch[j] ^ fout;
    end

    assign last      = (rnd == 5'(ROUNDS - UNROLL));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd   <= '0;
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            dec_q <= 1'b0;
            out_l <= '0;
            out_r <= '0;
        end else if (state == IDLE && in_valid) begin
            rnd        <= '0;
            l_q        <= in_l;
            r_q        <= in_r;
            {c_q, d_q} <= pc1(in_key);
            dec_q      <= in_decrypt;
        end else if (state == RUN) begin
            rnd <= rnd + 5'(UNROLL);
            l_q <= l_ch[UNROLL];
            r_q <= r_ch[UNROLL];
            c_q <= c_ch[UNROLL];
            d_q <= d_ch[UNROLL];
            if (last) begin
                out_l <= r_ch[UNROLL];
                out_r <= l_ch[UNROLL];
            end
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: known-answer vectors, unroll variants,
// stall/ignore behaviour, mid-run reset and a scoreboarded random stream.
module tb_des_round_engine;
    import des_pkg::*;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [31:0] KAT_L   = 32'hCC00CCFF;
    localparam logic [31:0] KAT_R   = 32'hF0AAF0AA;
    localparam logic [31:0] KAT_OL  = 32'h0A4CD995;
    localparam logic [31:0] KAT_OR  = 32'h43423234;
    localparam int UNR [4] = '{2, 4, 8, 16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [31:0] in_l, in_r;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_l, out_r;

    logic        x_valid;
    logic        x_in_ready  [4];
    logic        x_out_valid [4];
    logic [31:0] x_out_l     [4];
    logic [31:0] x_out_r     [4];

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_round_engine #(.UNROLL(1), .NUM_ROUNDS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_l       (in_l),
        .in_r       (in_r),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_l      (out_l),
        .out_r      (out_r)
    );

    for (genvar g = 0; g < 4; g++) begin : g_unr
        des_round_engine #(.UNROLL(UNR[g]), .NUM_ROUNDS(16)) u_x (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (x_valid),
            .in_ready   (x_in_ready[g]),
            .in_decrypt (in_decrypt),
            .in_l       (in_l),
            .in_r       (in_r),
            .in_key     (in_key),
            .out_valid  (x_out_valid[g]),
            .out_ready  (1'b1),
            .out_l      (x_out_l[g]),
            .out_r      (x_out_r[g])
        );
    end

    // Reference DES: full subkey list computed up front, reversed for decrypt.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [31:0] l0,
                                            input logic [31:0] r0, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] kk, x;
        logic [31:0] l, r, s, f, t;
        logic [5:0]  six;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = (cd << 1) | 56'((key >> (64 - PC1_TBL[6'(i)])) & 64'd1);
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < int'(SHIFTS[4'(i)]); n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            kk = '0;
            for (int j = 0; j < 48; j++) kk = (kk << 1) | 48'(({c, d} >> (56 - PC2_TBL[6'(j)])) & 56'd1);
            ks[4'(i)] = kk;
        end
        l = l0;
        r = r0;
        for (int i = 0; i < 16; i++) begin
            kk = dec ? ks[4'(15 - i)] : ks[4'(i)];
            x = '0;
            for (int j = 0; j < 48; j++) x = (x << 1) | 48'((r >> (32 - E_TBL[6'(j)])) & 32'd1);
            x = x ^ kk;
            s = '0;
            for (int j = 0; j < 8; j++) begin
                six = 6'(x >> (42 - 6 * j));
                s = (s << 4) | 32'(SBOX[3'(j)][{six[5], six[0], six[4:1]}]);
            end
            f = '0;
            for (int j = 0; j < 32; j++) f = (f << 1) | ((s >> (32 - P_TBL[5'(j)])) & 32'd1);
            t = r;
            r = l ^ f;
            l = t;
        end
        return {r, l};
    endfunction

    // Present one block from IDLE and wait for its result; lat counts cycles from the accept cycle.
    task automatic run_block(input logic [63:0] key, input logic [31:0] l, input logic [31:0] r,
                             input logic dec, output logic [63:0] res, output int lat);
        @(negedge clk);
        in_key = key; in_l = l; in_r = r; in_decrypt = dec;
        in_valid = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        res = {out_l, out_r};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; x_valid = 1'b0; out_ready = 1'b0;
        in_decrypt = 1'b0; in_l = '0; in_r = '0; in_key = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_l !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_l: got %h expected 0", out_l); end
        checks++; if (out_r !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_r: got %h expected 0", out_r); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
        for (int g = 0; g < 4; g++) begin
            checks++; if (x_in_ready[g] !== 1'b1 || x_out_valid[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_unroll%0d: got ready=%b valid=%b expected 1/0", UNR[g], x_in_ready[g], x_out_valid[g]); end
        end
    endtask

    task automatic test_encrypt();
        logic [63:0] res;
        int lat;
        run_block(KAT_KEY, KAT_L, KAT_R, 1'b0, res, lat);
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL enc_latency: got %0d expected 17", lat); end
        checks++; if (res !== {KAT_OL, KAT_OR}) begin errors++; $display("[TB] FAIL enc_result: got %h expected %h", res, {KAT_OL, KAT_OR}); end
    endtask

    task automatic test_decrypt();
        logic [63:0] res;
        int lat;
        run_block(KAT_KEY, KAT_OL, KAT_OR, 1'b1, res, lat);
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL dec_latency: got %0d expected 17", lat); end
        checks++; if (res !== {KAT_L, KAT_R}) begin errors++; $display("[TB] FAIL dec_result: got %h expected %h", res, {KAT_L, KAT_R}); end
    endtask

    task automatic test_unroll();
        int seen [4];
        logic [63:0] xres [4];
        int lat;
        for (int g = 0; g < 4; g++) begin seen[g] = -1; xres[g] = '0; end
        @(negedge clk);
        in_key = KAT_KEY; in_l = KAT_L; in_r = KAT_R; in_decrypt = 1'b0;
        x_valid = 1'b1;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            x_valid = 1'b0;
            lat++;
            for (int g = 0; g < 4; g++) begin
                if (x_out_valid[g] && seen[g] < 0) begin
                    seen[g] = lat;
                    xres[g] = {x_out_l[g], x_out_r[g]};
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            checks++; if (seen[g] != 16 / UNR[g] + 1) begin errors++; $display("[TB] FAIL unroll%0d_latency: got %0d expected %0d", UNR[g], seen[g], 16 / UNR[g] + 1); end
            checks++; if (xres[g] !== {KAT_OL, KAT_OR}) begin errors++; $display("[TB] FAIL unroll%0d_result: got %h expected %h", UNR[g], xres[g], {KAT_OL, KAT_OR}); end
        end
    endtask

    task automatic test_stall();
        int lat;
        @(negedge clk);
        in_key = KAT_KEY; in_l = KAT_L; in_r = KAT_R; in_decrypt = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        lat = 0;
        // Key, mode and data all change after accept, with stray in_valid pulses.
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'($urandom_range(0, 1));
            in_key = ~KAT_KEY; in_decrypt = 1'b1;
            in_l = $urandom; in_r = $urandom;
            if (lat == 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_run_ready: got %b expected 0", in_ready); end
            end
        end while (!out_valid && lat < 40);
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 17", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready%0d: got %b expected 0", i, in_ready); end
            checks++; if ({out_l, out_r} !== {KAT_OL, KAT_OR}) begin errors++; $display("[TB] FAIL stall_data%0d: got %h expected %h", i, {out_l, out_r}, {KAT_OL, KAT_OR}); end
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        checks++; if ({out_l, out_r} !== {KAT_OL, KAT_OR}) begin errors++; $display("[TB] FAIL idle_hold: got %h expected %h", {out_l, out_r}, {KAT_OL, KAT_OR}); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] res;
        int lat;
        int stray;
        @(negedge clk);
        in_key = KAT_KEY; in_l = KAT_OL; in_r = KAT_OR; in_decrypt = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); end
        checks++; if ({out_l, out_r} !== 64'h0) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 0", {out_l, out_r}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("[TB] FAIL midreset_discard: got %0d valid cycles expected 0", stray); end
        run_block(KAT_KEY, KAT_L, KAT_R, 1'b0, res, lat);
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected 17", lat); end
        checks++; if (res !== {KAT_OL, KAT_OR}) begin errors++; $display("[TB] FAIL postreset_result: got %h expected %h", res, {KAT_OL, KAT_OR}); end
    endtask

    task automatic test_back_to_back();
        int sent, recv, cyc;
        logic [63:0] exp_val, key;
        logic [31:0] l, r;
        logic dec;
        sent = 0; recv = 0; cyc = 0;
        exp_q.delete();
        @(negedge clk);
        while (recv < 100 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_extra: got %h expected no output", {out_l, out_r});
                end else begin
                    exp_val = exp_q.pop_front();
                    if ({out_l, out_r} !== exp_val) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", recv, {out_l, out_r}, exp_val); end
                    recv++;
                end
            end
            key = {$urandom, $urandom}; l = $urandom; r = $urandom; dec = 1'($urandom_range(0, 1));
            in_key = key; in_l = l; in_r = r; in_decrypt = dec;
            if (in_ready && sent < 100 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                exp_q.push_back(des_ref(key, l, r, dec));
                sent++;
            end else begin
                in_valid = !in_ready && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (recv != 100 || sent != 100) begin errors++; $display("[TB] FAIL b2b_count: got sent=%0d recv=%0d expected 100/100", sent, recv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_leftover: got %0d queued expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_unroll();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
